hs_arbiter: RTL and testbench

HS_ARBITER -- requirements
Module: hs_arbiter

---
 rtl/hs_arbiter.sv | 136 +++++++++++++
 tb/tb_hs_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hs_arbiter.sv
// rtl/hs_arbiter.sv - four-requester round-robin arbiter feeding a one-entry output register
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   per-requester valid, bit i is requester i
//   in_data    per-requester data, requester i at [i*DW +: DW]
//   in_ready   per-requester ready, one-hot or zero
//   in_last    per-requester end-of-burst marker (HS_ARB_LOCK_EN builds only)
//   out_valid  output register holds a beat
//   out_data   output beat data
//   out_src    requester index that supplied out_data
//   out_ready  downstream ready
//
// Configuration macro: HS_ARB_LOCK_EN adds burst locking via in_last; once a
// requester is granted with in_last=0 it keeps the grant until its in_last=1 beat.
module hs_arbiter #(
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
`ifdef HS_ARB_LOCK_EN
    input  logic [3:0]      in_last,
`endif
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_src,
    input  logic            out_ready
);

`ifdef HS_ARB_LOCK_EN
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    arb_state_e state_q, state_d;
    logic [1:0] lock_src_q, lock_src_d;
`endif

    logic [1:0]    ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_src_q, out_src_d;

    logic       gnt_found;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic       can_accept;
    logic       xfer;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand      = '0;
        // Search ptr, ptr+1, ... with 2-bit wraparound; first valid wins.
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_found && in_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
`ifdef HS_ARB_LOCK_EN
        // A burst in progress owns the output exclusively.
        if (state_q == LOCKED) begin
            gnt_found = in_valid[lock_src_q];
            gnt_idx   = lock_src_q;
        end
`endif

        // rst_n gating keeps in_ready low for the whole reset, not just after it.
        can_accept = rst_n && (!out_valid_q || out_ready);
        xfer       = can_accept && gnt_found;
        in_ready   = xfer ? (4'b0001 << gnt_idx) : 4'b0000;

        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
`ifdef HS_ARB_LOCK_EN
        state_d    = state_q;
        lock_src_d = lock_src_q;
`endif

        if (xfer) begin
            // Reload covers both the empty case and the drain-and-refill case.
            out_valid_d = 1'b1;
            out_data_d  = in_data[gnt_idx*DW +: DW];
            out_src_d   = gnt_idx;
`ifdef HS_ARB_LOCK_EN
            if (in_last[gnt_idx]) begin
                state_d = ARB;
                ptr_d   = gnt_idx + 2'd1;
            end else begin
                state_d    = LOCKED;
                lock_src_d = gnt_idx;
            end
`else
            ptr_d = gnt_idx + 2'd1;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
`ifdef HS_ARB_LOCK_EN
            state_q    <= ARB;
            lock_src_q <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
`ifdef HS_ARB_LOCK_EN
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_hs_arbiter.sv
// tb/tb_hs_arbiter.sv - scoreboard bench for hs_arbiter with a round-robin reference model
module tb_hs_arbiter;
    localparam int DW = 4;

    logic            clk;
    logic            rst_n;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_ready;
    logic [3:0]      in_last;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_ready;

    hs_arbiter #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef HS_ARB_LOCK_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]    src;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];

    // Reference model: abstract round-robin over a pointer and a one-deep output slot.
    int m_ptr;
    bit m_full;
    bit m_locked;
    int m_lsrc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ptr    = 0;
            m_full   = 0;
            m_locked = 0;
            m_lsrc   = 0;
            exp_q.delete();
        end else begin
            bit accept;
            int g;
            logic [3:0] exp_rdy;
            chk(out_valid === m_full, "out_valid", 32'(out_valid), 32'(m_full));
            accept = !m_full || out_ready;
            g = -1;
            if (m_locked) begin
                if (in_valid[m_lsrc]) g = m_lsrc;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 4;
                    if (g < 0 && in_valid[idx]) g = idx;
                end
            end
            exp_rdy = (accept && g >= 0) ? 4'(1 << g) : 4'b0000;
            chk(in_ready === exp_rdy, "in_ready", 32'(in_ready), 32'(exp_rdy));
            if (accept && g >= 0) begin
                beat_t b;
                b.src  = 2'(g);
                b.data = in_data[g*DW +: DW];
                exp_q.push_back(b);
                m_full = 1;
`ifdef HS_ARB_LOCK_EN
                if (in_last[g]) begin
                    m_locked = 0;
                    m_ptr    = (g + 1) % 4;
                end else begin
                    m_locked = 1;
                    m_lsrc   = g;
                end
`else
                m_ptr = (g + 1) % 4;
`endif
            end else if (out_ready) begin
                m_full = 0;
            end
        end
    end

    // Monitor: pops on every output transfer and checks hold stability under backpressure.
    bit            prev_hold;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_src;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                chk(out_valid === 1'b1, "hold_valid", 32'(out_valid), 32'd1);
                chk(out_data === prev_data, "hold_data", 32'(out_data), 32'(prev_data));
                chk(out_src === prev_src, "hold_src", 32'(out_src), 32'(prev_src));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", 32'(out_data), 32'd0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk(out_src === b.src, "out_src", 32'(out_src), 32'(b.src));
                    chk(out_data === b.data, "out_data", 32'(out_data), 32'(b.data));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_src  = out_src;
        end
    end

    // Applies inputs for one cycle; inputs change 1 time unit after posedge.
    task automatic cyc(input logic [3:0] v, input logic [15:0] d, input logic r, input logic [3:0] l);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        in_last   = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 16'hFFFF;
        out_ready = 1'b1;
        in_last   = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk(out_valid === 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
        chk(out_data === '0, "rst_out_data", 32'(out_data), 32'd0);
        chk(out_src === 2'd0, "rst_out_src", 32'(out_src), 32'd0);
        chk(in_ready === 4'b0000, "rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        // Single beat from requester 0.
        cyc(4'b0001, 16'h0005, 1'b1, 4'b1111);
        chk(out_valid === 1'b1 && out_data === 4'h5 && out_src === 2'd0, "single_beat",
            {27'd0, out_valid, out_data}, 32'h15);
        cyc(4'b0000, 16'h0000, 1'b1, 4'b1111);

        // All requesters valid, full throughput rotation.
        for (int i = 0; i < 8; i++) cyc(4'b1111, 16'hDCBA, 1'b1, 4'b1111);
        cyc(4'b0000, 16'h0000, 1'b1, 4'b1111);

        // Fill, then backpressure for 5 cycles with requesters 1 and 2 waiting.
        cyc(4'b0001, 16'h0007, 1'b0, 4'b1111);
        for (int i = 0; i < 5; i++) cyc(4'b0110, 16'h0320, 1'b0, 4'b1111);
        cyc(4'b0110, 16'h0320, 1'b1, 4'b1111);
        cyc(4'b0000, 16'h0000, 1'b1, 4'b1111);
        cyc(4'b0000, 16'h0000, 1'b1, 4'b1111);

        // Reset while holding 0xA.
        cyc(4'b0001, 16'h000A, 1'b0, 4'b1111);
        chk(out_valid === 1'b1 && out_data === 4'hA, "full_before_rst",
            {27'd0, out_valid, out_data}, 32'h1A);
        in_valid = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk(out_valid === 1'b0, "async_rst_valid", 32'(out_valid), 32'd0);
        chk(out_data === '0, "async_rst_data", 32'(out_data), 32'd0);
        in_valid = 4'b1000;
        #1;
        chk(in_ready === 4'b0000, "async_rst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b1000, 16'h9000, 1'b1, 4'b1111);
        chk(out_valid === 1'b1 && out_src === 2'd3, "post_rst_grant",
            {29'd0, out_valid, out_src}, 32'h7);
        cyc(4'b0000, 16'h0000, 1'b1, 4'b1111);

`ifdef HS_ARB_LOCK_EN
        // Requester 2 burst of three while requester 0 waits.
        cyc(4'b0100, 16'h0100, 1'b1, 4'b0000);
        cyc(4'b0101, 16'h0200, 1'b1, 4'b0000);
        cyc(4'b0101, 16'h0300, 1'b1, 4'b0100);
        cyc(4'b0001, 16'h0004, 1'b1, 4'b1111);
        cyc(4'b0000, 16'h0000, 1'b1, 4'b1111);
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 3) != 0),
                4'($urandom_range(0, 15)));
        end

        // Drain and confirm nothing was lost.
        for (int i = 0; i < 4; i++) cyc(4'b0000, 16'h0000, 1'b1, 4'b1111);
        chk(exp_q.size() == 0, "drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
